// File: rtl/pdl_arb_pkg.sv
// rtl/pdl_arb_pkg.sv - shared types and defaults for the PDL port arbiter
package pdl_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int WAIT_W         = 4;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CPU  = 2'd1,
        TAG_HOST = 2'd2
    } tag_t;

endpackage

// File: rtl/pdl_rd_tag_pipe.sv
// rtl/pdl_rd_tag_pipe.sv - shift register tracking the owner of each in-flight RAM read
module pdl_rd_tag_pipe
    import pdl_arb_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    input  tag_t push_tag,
    output tag_t pop_tag
);

    tag_t stage [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                stage[i] <= TAG_NONE;
            end
        end else begin
            stage[0] <= push_tag;
            for (int i = 1; i < RD_LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign pop_tag = stage[RD_LATENCY-1];

endmodule

// File: rtl/pdl_port_arbiter.sv
// rtl/pdl_port_arbiter.sv - CPU/HOST arbiter for one port of the PDL RAM with read-return routing
module pdl_port_arbiter
    import pdl_arb_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int RD_LATENCY    = 2,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ack,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_wren,
    output logic                  ram_rden,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    logic              force_host;
    logic              cpu_grant;
    logic              host_grant;
    logic [WAIT_W-1:0] wait_cnt;
    tag_t              cmd_tag;
    tag_t              push_tag;
    tag_t              pop_tag;
    logic [DATA_WIDTH-1:0] cpu_rdata_q;
    logic [DATA_WIDTH-1:0] host_rdata_q;

    // Grants are suppressed during reset so nothing is captured in that cycle.
    always_comb begin
        force_host = (wait_cnt == WAIT_W'(HOST_MAX_WAIT));
        host_grant = !reset && host_req && (!cpu_req || force_host);
        cpu_grant  = !reset && cpu_req && !host_grant;
    end

    assign cpu_ack  = cpu_grant;
    assign host_ack = host_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wren  <= 1'b0;
            ram_rden  <= 1'b0;
            cmd_tag   <= TAG_NONE;
        end else begin
            ram_wren <= 1'b0;
            ram_rden <= 1'b0;
            cmd_tag  <= TAG_NONE;
            if (cpu_grant) begin
                ram_addr  <= cpu_addr;
                ram_wdata <= cpu_wdata;
                ram_wren  <= cpu_we;
                ram_rden  <= !cpu_we;
                cmd_tag   <= TAG_CPU;
            end else if (host_grant) begin
                ram_addr  <= host_addr;
                ram_wdata <= host_wdata;
                ram_wren  <= host_we;
                ram_rden  <= !host_we;
                cmd_tag   <= TAG_HOST;
            end
        end
    end

    // Saturating count of consecutive denied HOST cycles.
    always_ff @(posedge clk) begin
        if (reset || !host_req || host_ack) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_W'(HOST_MAX_WAIT) && wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign push_tag = ram_rden ? cmd_tag : TAG_NONE;

    pdl_rd_tag_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .push_tag (push_tag),
        .pop_tag  (pop_tag)
    );

    // rvalid lines up with ram_q; the registered copy keeps rdata stable between pulses.
    assign cpu_rvalid  = !reset && (pop_tag == TAG_CPU);
    assign host_rvalid = !reset && (pop_tag == TAG_HOST);
    assign cpu_rdata   = cpu_rvalid  ? ram_q : cpu_rdata_q;
    assign host_rdata  = host_rvalid ? ram_q : host_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) begin
                cpu_rdata_q <= ram_q;
            end
            if (host_rvalid) begin
                host_rdata_q <= ram_q;
            end
        end
    end

endmodule

// File: tb/tb_pdl_port_arbiter.sv
// tb/tb_pdl_port_arbiter.sv - scoreboard bench for pdl_port_arbiter with a RAM model
module tb_pdl_port_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wren, ram_rden;
    logic [DW-1:0] ram_q;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cpu_rv_n  = 0;
    int host_rv_n = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          cpu_q[$];
    exp_t          host_q[$];
    logic [DW-1:0] shadow [1024];

    logic [DW-1:0] mem [1024];
    logic [DW-1:0] qp  [LAT];

    pdl_port_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .RD_LATENCY    (LAT),
        .HOST_MAX_WAIT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_wren    (ram_wren),
        .ram_rden    (ram_rden),
        .ram_q       (ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: q valid LAT cycles after the rden cycle.
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        qp[0] <= mem[ram_addr];
        for (int i = 1; i < LAT; i++) qp[i] <= qp[i-1];
    end
    assign ram_q = qp[LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: push on ack, pop and compare on rvalid.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            cpu_q.delete();
            host_q.delete();
        end else begin
            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) check("cpu_spurious_rvalid", 1, 0);
                else begin
                    e = cpu_q.pop_front();
                    check("cpu_rdata", cpu_rdata, e.data);
                    check("cpu_rlat", cyc, e.due);
                    cpu_rv_n++;
                end
            end
            if (host_rvalid) begin
                if (host_q.size() == 0) check("host_spurious_rvalid", 1, 0);
                else begin
                    e = host_q.pop_front();
                    check("host_rdata", host_rdata, e.data);
                    check("host_rlat", cyc, e.due);
                    host_rv_n++;
                end
            end
            if (cpu_ack && host_ack) check("ack_excl", 1, 0);
            if (ram_wren && ram_rden) check("wren_rden_excl", 1, 0);
            if (cpu_ack) begin
                if (cpu_we) shadow[cpu_addr] = cpu_wdata;
                else cpu_q.push_back('{data: shadow[cpu_addr], due: cyc + 1 + LAT});
            end else if (host_ack) begin
                if (host_we) shadow[host_addr] = host_wdata;
                else host_q.push_back('{data: shadow[host_addr], due: cyc + 1 + LAT});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (cpu_ack) got = 1;
        end
        check("cpu_op_ack", got, 1);
        tick();
        cpu_req = 1'b0;
    endtask

    initial begin
        int hv_before;
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        repeat (3) tick();
        reset = 1'b0;

        // reset / idle
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_outs", {ram_addr, ram_wdata, ram_wren, ram_rden, cpu_ack, host_ack,
                                cpu_rvalid, host_rvalid, cpu_rdata, host_rdata}, 0);
        end
        tick();

        // CPU write then read of the same address
        cpu_op(1'b1, 10'o17, 32'h1234_5678);
        cpu_op(1'b0, 10'o17, '0);
        repeat (6) tick();
        check("cpu_rv_after_wr_rd", cpu_rv_n, 1);
        check("cpu_rdata_hold", cpu_rdata, 32'h1234_5678);

        // preload 0..3
        for (int i = 0; i < 4; i++) cpu_op(1'b1, AW'(i), DW'(10 + i));

        // simultaneous requests
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'd1;
        host_req = 1; host_we = 0; host_addr = 10'd2;
        @(negedge clk);
        check("sim_cpu_ack", cpu_ack, 1);
        check("sim_host_ack", host_ack, 0);
        tick();
        cpu_req = 0;
        @(negedge clk);
        check("sim_host_next", host_ack, 1);
        tick();
        host_req = 0;
        repeat (6) tick();

        // starvation guard
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'd0;
        host_req = 1; host_we = 0; host_addr = 10'd3;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("starve_host_ack_%0d", k), host_ack, k == 5);
            check($sformatf("starve_cpu_ack_%0d", k), cpu_ack, k != 5);
            tick();
            if (k == 5) host_req = 0;
        end
        cpu_req = 0;
        repeat (6) tick();
        check("starve_host_rv", host_rv_n, 2);

        // back-to-back CPU reads 0..3
        hv_before = cpu_rv_n;
        cpu_req = 1; cpu_we = 0;
        for (int i = 0; i < 4; i++) begin
            cpu_addr = AW'(i);
            @(negedge clk);
            check("b2b_ack", cpu_ack, 1);
            tick();
        end
        cpu_req = 0;
        repeat (6) tick();
        check("b2b_rv_count", cpu_rv_n - hv_before, 4);
        check("b2b_last_rdata", cpu_rdata, 32'd13);

        // HOST read dropped by reset
        hv_before = host_rv_n;
        host_req = 1; host_we = 0; host_addr = 10'd2;
        @(negedge clk);
        check("rst_host_ack", host_ack, 1);
        tick();
        host_req = 0;
        reset = 1;
        tick();
        reset = 0;
        repeat (6) @(negedge clk);
        check("rst_no_rvalid", host_rv_n, hv_before);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);

        check("cpu_q_drained", cpu_q.size(), 0);
        check("host_q_drained", host_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
